mux16_scan_ctrl: RTL and testbench
==================================

# mux16_scan_ctrl

Upstream sequencer for the 16:1 bit multiplexer (`muxer16`): accepts a 16-bit word over a valid/ready handshake, holds it on the mux data inputs, and steps the mux select through all 16 positions. It registers each selected bit into a serial valid/ready stream with a last-bit marker. It also checks every mux output against the expected bit and raises a sticky error flag on mismatch.

## Interface
- `MSB_FIRST`, default 0: 0 scans select 0→15; 1 scans select 15→0.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_word` input 16: parallel word to serialize.
- `in_valid` input 1: `in_word` is valid.
- `in_ready` output 1: block can accept a word; equals (state==IDLE).
- `mux_in` output 16: latched word; drives `muxer16.in`.
- `mux_sel` output 4: registered select; drives `muxer16.sel`.
- `mux_q` input 1: `muxer16.q`, combinational from `mux_in`/`mux_sel`.
- `ser_bit` output 1: serialized bit.
- `ser_valid` output 1: `ser_bit` is valid.
- `ser_last` output 1: `ser_bit` is the final bit of the word.
- `ser_ready` input 1: downstream accepts `ser_bit`.
- `busy` output 1: state != IDLE.
- `err` output 1: sticky; `mux_q` differed from `mux_in[mux_sel]` on a capture.

## Operation
- Reset values: state=IDLE, `mux_in`=0, `mux_sel`=0, `ser_bit`=0, `ser_valid`=0, `ser_last`=0, `err`=0.
  - `in_ready`=1 during reset, since it is decoded from IDLE.
  - Inputs are ignored while `rst_n`=0.
- Start index is 0 when `MSB_FIRST`=0 and 15 otherwise. End index is the opposite value.
- IDLE:
  - On `in_valid` & `in_ready`: latch `in_word` into `mux_in`, set `mux_sel` to the start index, and go to SCAN.
  - Without a handshake, `mux_in` and `mux_sel` hold.
- SCAN:
  - Capture is enabled when `ser_valid`=0, or when `ser_valid` & `ser_ready`.
  - On capture: `ser_bit`←`mux_q`, `ser_valid`←1, and `ser_last`←(`mux_sel`==end index).
  - On capture, `err` is set (set-only) if `mux_q` != `mux_in[mux_sel]`.
  - If the captured index is not the end index, `mux_sel` steps ±1 (see `MSB_FIRST`); otherwise go to DRAIN with `mux_sel` held.
  - Without capture (backpressure), `mux_sel`, `ser_bit` and `ser_last` hold.
- DRAIN: on `ser_valid` & `ser_ready`, set `ser_valid`←0 and `ser_last`←0, then go to IDLE.
- `mux_in` is stable from latch until the next accepted word; it is never modified in SCAN or DRAIN.
- `mux_sel` only changes on load or on a SCAN capture, so the mux output settles a full cycle before it is sampled.
- `in_valid` in SCAN or DRAIN is not accepted: `in_ready`=0 and the word is not latched.
- `err` clears only on reset.
- Reset mid-word: everything returns to its reset value immediately. The partial word is discarded and no `ser_last` is emitted.

## Timing
- Word accepted at edge of cycle t (`ser_ready` held 1):
  - `mux_sel` = start index during cycle t+1.
  - Bit k (scan order) is valid on `ser_bit` during cycle t+2+k.
  - `ser_last`=1 during cycle t+17.
  - `in_ready`=1 again in cycle t+18.
- Throughput: one word per 18 cycles. Each cycle of `ser_ready`=0 while `ser_valid`=1 adds one cycle.
- `mux_q` is sampled combinationally in the same cycle as `mux_sel` is presented. The mux lies in a single-cycle path from `mux_sel`/`mux_in` registers to the `ser_bit`/`err` registers.
- No combinational path from `ser_ready` or `in_valid` to any output; `in_ready` depends on state only.

## Test plan
- Reset, then word 0xA5C3 with `MSB_FIRST`=0 and `ser_ready`=1: bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on cycles t+2..t+17. `ser_last` is set only at t+17, `in_ready` returns at t+18, and `err`=0.
- Same word with `MSB_FIRST`=1: order reversed (1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1), and `mux_sel` runs 15→0.
- Random `ser_ready` deasserts (including on the last bit): the received stream equals the word; `mux_sel`, `ser_bit` and `ser_last` are stable while stalled; no bits are dropped or duplicated.
- Back-to-back words 0xFFFF then 0x0001 with `in_valid` held: the second word is accepted only at t+18, and both streams are correct.
- Bench forces `mux_q` inverted for one capture at index 5: `err` rises the cycle after that capture and stays 1 across later words until `rst_n` pulses.
- `rst_n` pulled low at bit 7: all outputs go to reset values asynchronously. After release, a new word 0x1234 serializes correctly from bit 0.

Source files
------------

// File: rtl/mux16_scan_ctrl.sv
// Sequencer for a 16:1 bit mux: latches a word, walks the select through all
// positions, streams each selected bit out and flags any mux output mismatch.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a new word; mux_in/mux_sel hold their last value
// SCAN  | stepping mux_sel, capturing mux_q into the serial register
// DRAIN | last bit is presented, waiting for downstream to take it
module mux16_scan_ctrl #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mux_in,
  output logic [3:0]  mux_sel,
  input  logic        mux_q,
  output logic        ser_bit,
  output logic        ser_valid,
  output logic        ser_last,
  input  logic        ser_ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] START_IDX = MSB_FIRST ? 4'd15 : 4'd0;
  localparam logic [3:0] END_IDX   = MSB_FIRST ? 4'd0  : 4'd15;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] mux_in_d;
  logic [3:0]  mux_sel_d;
  logic        ser_bit_d;
  logic        ser_valid_d;
  logic        ser_last_d;
  logic        err_d;

  logic        ser_take;
  logic        capture;
  logic        at_end;
  logic        exp_bit;
  logic [3:0]  sel_step;

  assign ser_take = ser_valid & ser_ready;
  // A new bit may enter the output register when it is empty or being drained.
  assign capture  = (state_q == SCAN) & (~ser_valid | ser_ready);
  assign at_end   = (mux_sel == END_IDX);
  assign exp_bit  = mux_in[mux_sel];
  assign sel_step = MSB_FIRST ? (mux_sel - 4'd1) : (mux_sel + 4'd1);

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mux_in    <= 16'h0000;
      mux_sel   <= 4'd0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      mux_in    <= mux_in_d;
      mux_sel   <= mux_sel_d;
      ser_bit   <= ser_bit_d;
      ser_valid <= ser_valid_d;
      ser_last  <= ser_last_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mux_in_d    = mux_in;
    mux_sel_d   = mux_sel;
    ser_bit_d   = ser_bit;
    ser_valid_d = ser_valid;
    ser_last_d  = ser_last;
    err_d       = err;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mux_in_d  = in_word;
          mux_sel_d = START_IDX;
          state_d   = SCAN;
        end
      end

      SCAN: begin
        if (capture) begin
          ser_bit_d   = mux_q;
          ser_valid_d = 1'b1;
          ser_last_d  = at_end;
          if (mux_q != exp_bit) begin
            err_d = 1'b1;
          end
          // Select stays on the end index through DRAIN; reloaded on next word.
          if (at_end) begin
            state_d = DRAIN;
          end else begin
            mux_sel_d = sel_step;
          end
        end
      end

      DRAIN: begin
        if (ser_take) begin
          ser_valid_d = 1'b0;
          ser_last_d  = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Bench for mux16_scan_ctrl: LSB-first and MSB-first instances run in lockstep
// against a bit-position model of the serial stream, with a behavioural mux.
module tb_mux16_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_word;
  logic        in_valid;
  logic        ser_ready;
  logic        inv_en;

  logic [15:0] min   [2];
  logic [3:0]  sel   [2];
  logic        sbit  [2];
  logic        sval  [2];
  logic        slast [2];
  logic        irdy  [2];
  logic        bsy   [2];
  logic        er    [2];
  logic        mq    [2];

  int passed;
  int total;
  bit sticky;
  bit aborted;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 16:1 mux; inv_en corrupts the output whenever select is 5.
  assign mq[0] = min[0][sel[0]] ^ (inv_en && (sel[0] == 4'd5));
  assign mq[1] = min[1][sel[1]] ^ (inv_en && (sel[1] == 4'd5));

  mux16_scan_ctrl #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid),
    .in_ready(irdy[0]), .mux_in(min[0]), .mux_sel(sel[0]), .mux_q(mq[0]),
    .ser_bit(sbit[0]), .ser_valid(sval[0]), .ser_last(slast[0]),
    .ser_ready(ser_ready), .busy(bsy[0]), .err(er[0])
  );

  mux16_scan_ctrl #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid),
    .in_ready(irdy[1]), .mux_in(min[1]), .mux_sel(sel[1]), .mux_q(mq[1]),
    .ser_bit(sbit[1]), .ser_valid(sval[1]), .ser_last(slast[1]),
    .ser_ready(ser_ready), .busy(bsy[1]), .err(er[1])
  );

  task automatic chk1(input string tag, input int d, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s dut%0d observed=%0b expected=%0b", tag, d, obs, exp);
  endtask

  task automatic chk16(input string tag, input int d, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
  endtask

  // Select index of scan position k: dut0 scans upward, dut1 downward.
  function automatic logic [3:0] idx(input int d, input int k);
    return (d == 1) ? 4'(15 - k) : 4'(k);
  endfunction

  function automatic logic expbit(input logic [15:0] w, input int d, input int k, input bit inv);
    logic [3:0] i;
    i = idx(d, k);
    return w[i] ^ (inv && (i == 4'd5));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk16({tag, "_mux_in"}, d, min[d], 16'h0000);
      chk16({tag, "_mux_sel"}, d, 16'(sel[d]), 16'h0000);
      chk1({tag, "_ser_bit"}, d, sbit[d], 1'b0);
      chk1({tag, "_ser_valid"}, d, sval[d], 1'b0);
      chk1({tag, "_ser_last"}, d, slast[d], 1'b0);
      chk1({tag, "_err"}, d, er[d], 1'b0);
      chk1({tag, "_in_ready"}, d, irdy[d], 1'b1);
      chk1({tag, "_busy"}, d, bsy[d], 1'b0);
    end
  endtask

  // Sends one word from an idle cycle and follows the stream cycle by cycle.
  // cap = bits captured so far, have = a bit is held on the serial output.
  task automatic run_word(input logic [15:0] w, input bit inv, input int stall_pct,
                          input bit chain, input logic [15:0] nxt, input int abort_at,
                          output bit was_aborted);
    int  cap;
    bit  have;
    bit  rdy;
    bit  done;
    was_aborted = 1'b0;
    for (int d = 0; d < 2; d++) chk1("in_ready_idle", d, irdy[d], 1'b1);
    in_word  = w;
    in_valid = 1'b1;
    inv_en   = inv;
    tick();
    cap  = 0;
    have = 1'b0;
    done = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      in_valid = chain ? 1'b1 : 1'($urandom_range(1));
      in_word  = chain ? nxt : 16'($urandom);
      for (int d = 0; d < 2; d++) begin
        chk1("ser_valid", d, sval[d], have);
        if (have) chk1("ser_bit", d, sbit[d], expbit(w, d, cap - 1, inv));
        chk1("ser_last", d, slast[d], have && (cap == 16));
        chk16("mux_sel", d, 16'(sel[d]), 16'(idx(d, (cap < 16) ? cap : 15)));
        chk16("mux_in_hold", d, min[d], w);
        chk1("in_ready_busy", d, irdy[d], 1'b0);
        chk1("busy", d, bsy[d], 1'b1);
        chk1("err", d, er[d], sticky || (inv && (cap > ((d == 1) ? 10 : 5))));
      end
      if (abort_at >= 0 && have && (cap - 1) == abort_at) begin
        was_aborted = 1'b1;
        return;
      end
      rdy = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= stall_pct);
      ser_ready = rdy;
      tick();
      if (cap < 16 && (!have || rdy)) begin
        cap++;
        have = 1'b1;
      end else if (have && rdy) begin
        have = 1'b0;
      end
      if (cap == 16 && !have) done = 1'b1;
    end
    if (!done) begin
      chk1("word_timeout", 0, 1'b1, 1'b0);
      return;
    end
    in_valid = chain;
    for (int d = 0; d < 2; d++) begin
      chk1("end_ser_valid", d, sval[d], 1'b0);
      chk1("end_ser_last", d, slast[d], 1'b0);
      chk1("end_in_ready", d, irdy[d], 1'b1);
      chk1("end_busy", d, bsy[d], 1'b0);
      chk1("end_err", d, er[d], sticky || inv);
      chk16("end_mux_in", d, min[d], w);
      chk16("end_mux_sel", d, 16'(sel[d]), 16'(idx(d, 15)));
    end
    if (inv) sticky = 1'b1;
    inv_en = 1'b0;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    sticky    = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_word   = 16'hBEEF;
    ser_ready = 1'b1;
    inv_en    = 1'b0;

    // Inputs are ignored while reset is held.
    repeat (3) tick();
    check_reset("reset");
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    check_reset("post_reset");

    run_word(16'hA5C3, 1'b0, 0, 1'b0, 16'h0, -1, aborted);

    for (int i = 0; i < 4; i++)
      run_word(16'($urandom), 1'b0, 40, 1'b0, 16'h0, -1, aborted);

    run_word(16'hFFFF, 1'b0, 0, 1'b1, 16'h0001, -1, aborted);
    run_word(16'h0001, 1'b0, 0, 1'b0, 16'h0, -1, aborted);

    run_word(16'($urandom), 1'b1, 0, 1'b0, 16'h0, -1, aborted);
    run_word(16'($urandom), 1'b0, 30, 1'b0, 16'h0, -1, aborted);

    // Only a reset pulse clears the sticky error.
    #2 rst_n = 1'b0;
    #1 check_reset("err_clear");
    sticky = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    run_word(16'($urandom), 1'b0, 0, 1'b0, 16'h0, 7, aborted);
    chk1("abort_reached", 0, aborted, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset");
    tick();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    tick();
    check_reset("after_abort");

    run_word(16'h1234, 1'b0, 0, 1'b0, 16'h0, -1, aborted);
    run_word(16'($urandom), 1'b0, 50, 1'b0, 16'h0, -1, aborted);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
